// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: boot hold-off, load-use/branch bubbles, data-memory stall.
// Optional perf counters (stall_cycles, flush_count) enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_raddr,
  input  logic [4:0]  rs2_raddr,
  input  logic [4:0]  rd_waddr_EX,
  input  logic        memread_EX,
  input  logic        branch_valid,
  input  logic        jalr_ID,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_running,
  output logic        keep_instr,
  output logic        bubble_EX,
  output logic        stall_all,
  output logic        jalr_EX,
  output logic        jalr_M,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] boot_cnt;
  logic       load_use;

  assign load_use = memread_EX && (rd_waddr_EX != 5'd0) &&
                    ((rd_waddr_EX == rs1_raddr) || (rd_waddr_EX == rs2_raddr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == BOOT) boot_cnt <= boot_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_running = 1'b0;
    stall_all  = 1'b0;
    keep_instr = 1'b0;
    bubble_EX  = 1'b0;
    case (state)
      BOOT: if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      RUN: begin
        pc_running = 1'b1;
        if (dmem_req && !dmem_ready) begin
          stall_all = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        pc_running = 1'b1;
        // the ready cycle completes the access, so the pipeline advances on it
        if (dmem_ready) state_nxt = RUN;
        else            stall_all = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
    if (state != BOOT) begin
      if (stall_all) begin
        keep_instr = 1'b1;
      end else if (branch_valid) begin
        bubble_EX  = 1'b1;
      end else if (state == RUN && load_use) begin
        keep_instr = 1'b1;
        bubble_EX  = 1'b1;
      end
    end
    // outputs read as idle while reset is held, not only after its edge
    if (!rst_n) begin
      pc_running = 1'b0;
      stall_all  = 1'b0;
      keep_instr = 1'b0;
      bubble_EX  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jalr_EX <= 1'b0;
      jalr_M  <= 1'b0;
    end else if (!stall_all) begin
      jalr_EX <= jalr_ID && !keep_instr && !branch_valid;
      jalr_M  <= jalr_EX;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (keep_instr && state != BOOT && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (branch_valid && !stall_all && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
